sa_result_drain: RTL and testbench

- Output-side companion of the 3x3 systolic array top.
- Captures the flat N*N result matrix presented with the array's valid_out pulse.
- Streams the result one element per handshake, in row-major order, over a valid/ready interface to downstream logic (memory writer, UART, checker).
- Absorbs downstream backpressure and flags results the array produces while a previous matrix is still draining.

---
 rtl/sa_result_drain_if.sv | 28 ++
 rtl/sa_result_drain.sv | 91 +++++++++
 tb/tb_sa_result_drain.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sa_result_drain_if.sv
// Handshake bundle between the systolic array result port, the drain and the downstream consumer.
// The slave modport is the drain; the master modport is the array/consumer side.
interface sa_result_drain_if #(
  parameter int N     = 3,
  parameter int OUT_W = 16,
  parameter int IDX_W = 4
);
  logic                   res_valid;
  logic [N*N*OUT_W-1:0]   res_data;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [IDX_W-1:0]       out_row;
  logic [IDX_W-1:0]       out_col;
  logic                   out_last;
  logic                   overrun;

  modport slave (
    input  res_valid, res_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last, overrun
  );

  modport master (
    output res_valid, res_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last, overrun
  );
endinterface

// File: rtl/sa_result_drain.sv
// Captures a flat N*N result matrix and streams it row-major over valid/ready,
// flagging results that arrive while a previous matrix is still draining.
module sa_result_drain #(
  parameter int N     = 3,
  parameter int OUT_W = 16,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  sa_result_drain_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  localparam int BUF_W = N * N * OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             overrun_q, overrun_d;

  logic outValid;
  logic lastElem;
  logic xfer;
  logic inReady;
  logic capture;

  always_comb begin
    outValid = (state_q == STREAM);
    lastElem = outValid && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    xfer     = outValid && bus.out_ready;
    inReady  = (state_q == IDLE) || (xfer && lastElem);
    capture  = bus.res_valid && inReady;
  end

  // The buffer shifts down one element per transfer, so the current element is always in the low slot.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q | (bus.res_valid & ~inReady);

    if (capture) begin
      state_d = STREAM;
      buf_d   = bus.res_data;
      row_d   = '0;
      col_d   = '0;
    end else if (xfer) begin
      buf_d = {{OUT_W{1'b0}}, buf_q[BUF_W-1:OUT_W]};
      if (lastElem) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end else if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = buf_q[OUT_W-1:0];
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = lastElem;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: basic drain, backpressure, back-to-back,
// overrun and mid-stream reset, checked with immediate assertions.
module tb_sa_result_drain;

  localparam int N     = 3;
  localparam int OUT_W = 16;
  localparam int IDX_W = 4;

  logic clk;
  logic reset;
  int   numAsserts;
  int   numFails;

  sa_result_drain_if #(.N(N), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

  sa_result_drain #(.N(N), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*N*OUT_W-1:0] makeMat(input int base);
    logic [N*N*OUT_W-1:0] m;
    m = '0;
    for (int k = 0; k < N*N; k++) m[k*OUT_W +: OUT_W] = OUT_W'(base + k);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input int base, input logic rdy);
    bus.res_valid = rv;
    bus.res_data  = makeMat(base);
    bus.out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numAsserts++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkElem(input string tag, input int data, input int row, input int col);
    checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, " data"},  32'(bus.out_data),  32'(data));
    checkOutput({tag, " row"},   32'(bus.out_row),   32'(row));
    checkOutput({tag, " col"},   32'(bus.out_col),   32'(col));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rdyPattern [3] = '{1, 0, 0};
    int nextVal;
    int cyc;

    numAsserts = 0;
    numFails   = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst out_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst out_row",   32'(bus.out_row),   32'd0);
    checkOutput("rst out_col",   32'(bus.out_col),   32'd0);
    checkOutput("rst out_last",  32'(bus.out_last),  32'd0);
    checkOutput("rst overrun",   32'(bus.overrun),   32'd0);
    checkOutput("rst in_ready",  32'(bus.in_ready),  32'd1);

    $display("[TB] basic drain");
    applyStimulus(1'b1, 1, 1'b1);
    tick();
    bus.res_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checkElem("basic", i + 1, i / 3, i % 3);
      checkOutput("basic out_last", 32'(bus.out_last), 32'(i == 8));
      checkOutput("basic in_ready", 32'(bus.in_ready), 32'(i == 8));
      tick();
    end
    checkOutput("basic idle valid", 32'(bus.out_valid), 32'd0);
    checkOutput("basic idle ready", 32'(bus.in_ready),  32'd1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1, 1'b1);
    tick();
    bus.res_valid = 1'b0;
    nextVal = 1;
    cyc = 0;
    while (nextVal <= 9 && cyc < 40) begin
      bus.out_ready = 1'(rdyPattern[cyc % 3]);
      checkOutput("bp valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp data",  32'(bus.out_data),  32'(nextVal));
      checkOutput("bp last",  32'(bus.out_last),  32'(nextVal == 9));
      if (bus.out_ready) nextVal++;
      cyc++;
      tick();
    end
    checkOutput("bp all delivered", 32'(nextVal), 32'd10);
    checkOutput("bp idle valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1, 1'b1);
    tick();
    bus.res_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkElem("b2b final", 9, 2, 2);
    applyStimulus(1'b1, 'h11, 1'b1);
    checkOutput("b2b in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.res_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checkElem("b2b second", 'h11 + i, i / 3, i % 3);
      tick();
    end
    checkOutput("b2b overrun", 32'(bus.overrun), 32'd0);
    checkOutput("b2b idle valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] overrun");
    applyStimulus(1'b1, 1, 1'b1);
    tick();
    bus.res_valid = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b0;
    checkElem("ovr stall", 3, 0, 2);
    tick();
    checkElem("ovr held", 3, 0, 2);
    applyStimulus(1'b1, 'h21, 1'b0);
    checkOutput("ovr in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.res_valid = 1'b0;
    checkOutput("ovr set", 32'(bus.overrun), 32'd1);
    checkElem("ovr still held", 3, 0, 2);
    bus.out_ready = 1'b1;
    for (int i = 2; i < 9; i++) begin
      checkElem("ovr continue", i + 1, i / 3, i % 3);
      checkOutput("ovr sticky", 32'(bus.overrun), 32'd1);
      tick();
    end
    checkOutput("ovr idle valid", 32'(bus.out_valid), 32'd0);
    checkOutput("ovr idle sticky", 32'(bus.overrun), 32'd1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1, 1'b1);
    tick();
    bus.res_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkElem("mid sixth", 6, 1, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid overrun",   32'(bus.overrun),   32'd0);
    checkOutput("mid in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("mid out_data",  32'(bus.out_data),  32'd0);
    applyStimulus(1'b1, 'h31, 1'b1);
    tick();
    bus.res_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checkElem("mid reload", 'h31 + i, i / 3, i % 3);
      tick();
    end
    checkOutput("mid idle valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
